// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master, MSB-first, 1..MAX_BYTES bytes per transfer.
// Programmable SCLK half-period (clk_div+1 clk cycles), all four CPOL/CPHA modes,
// NUM_CS active-low chip selects and a start/done handshake towards the CPU side.
module spi_master_param #(
  parameter  int MAX_BYTES = 8,
  parameter  int NUM_CS    = 1,
  parameter  int DIV_WIDTH = 8,
  localparam int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic [LEN_W-1:0]       len,
  input  logic [CS_W-1:0]        cs_sel,
  input  logic [DIV_WIDTH-1:0]   clk_div,
  input  logic                   cpol,
  input  logic                   cpha,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic [NUM_CS-1:0]      cs_n
);

  localparam int DW  = 8 * MAX_BYTES;
  // bit counter width, plus one more bit so the edge counter holds 2N
  localparam int BCW = $clog2(DW) + 1;
  localparam int EW  = BCW + 1;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t               state;
  logic [DW-1:0]        tx_sh;
  logic [DW-1:0]        rx_sh;
  logic [LEN_W-1:0]     len_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 cpha_q;
  logic [EW-1:0]        edge_cnt;   // sclk edges already issued in this transfer
  logic [EW-1:0]        nedges;     // 2N
  logic [EW-1:0]        shamt;      // DW - N, aligns received bits to the MSB
  logic [NUM_CS-1:0]    cs_dec;
  logic                 tick;
  logic                 lead;
  logic                 xfer_end;

  assign nedges   = (EW'(len_q) + EW'(1)) << 4;
  assign shamt    = EW'(DW) - (nedges >> 1);
  assign tick     = (div_cnt == div_q);
  // edges are numbered from 1; odd-numbered edges are leading edges
  assign lead     = ~edge_cnt[0];
  assign xfer_end = (state == XFER) && (edge_cnt == nedges);

  // one-hot-low chip select decode; an out-of-range index selects nothing
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) cs_dec[i] = (int'(cs_sel) != i);
  end

  // transfer sequencer: IDLE -> LEAD -> XFER -> TRAIL -> IDLE, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sclk     <= 1'b0;
      cs_n     <= '1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      len_q    <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          if (start) begin
            len_q    <= len;
            div_q    <= clk_div;
            cpha_q   <= cpha;
            rx_sh    <= '0;
            rx_data  <= '0;
            busy     <= 1'b1;
            cs_n     <= cs_dec;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= LEAD;
            // cpha=0 needs the first bit on the wire before the first (sampling) edge
            if (!cpha) begin
              mosi  <= tx_data[DW-1];
              tx_sh <= {tx_data[DW-2:0], 1'b0};
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        LEAD, XFER: begin
          if (tick) begin
            div_cnt <= '0;
            if (xfer_end) begin
              state <= TRAIL;
            end else begin
              state    <= XFER;
              sclk     <= ~sclk;
              edge_cnt <= edge_cnt + EW'(1);
              if (lead ^ cpha_q) begin
                rx_sh <= {rx_sh[DW-2:0], miso};
              end else if (edge_cnt + EW'(1) == nedges) begin
                // final trailing edge in cpha=0: nothing left to send
                mosi <= 1'b0;
              end else begin
                mosi  <= tx_sh[DW-1];
                tx_sh <= {tx_sh[DW-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        TRAIL: begin
          if (tick) begin
            div_cnt <= '0;
            state   <= IDLE;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_sh << shamt;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: behavioural SPI slave, bus monitor and
// arithmetic expectations for rx data, chip-select timing and sclk edge counts.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] tx_data = '0;
  logic [2:0]  len = '0;
  logic [1:0]  cs_sel = '0;
  logic [7:0]  clk_div = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        busy, done, sclk, mosi, miso;
  logic [63:0] rx_data;
  logic [3:0]  cs_n;

  int checks = 0;
  int errors = 0;

  spi_master_param #(.MAX_BYTES(8), .NUM_CS(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .len(len),
    .cs_sel(cs_sel), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0, loopback = 1'b0;
  logic [63:0] s_word = '0, s_sh = '0, s_rx = '0;
  logic        s_miso = 1'b0;
  logic        cs_act;
  assign cs_act = ~&cs_n;
  assign miso   = loopback ? mosi : s_miso;

  always @(posedge cs_act) begin
    s_rx = '0;
    s_sh = s_word;
    if (!cur_cpha) begin
      s_miso = s_sh[63];
      s_sh   = s_sh << 1;
    end
  end

  always @(sclk) begin
    if (cs_act === 1'b1) begin
      if ((sclk !== cur_cpol) != cur_cpha) begin
        s_rx = {s_rx[62:0], mosi};
      end else begin
        s_miso = s_sh[63];
        s_sh   = s_sh << 1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int   cyc = 0, low_run = 0, high_run = 0, last_low = 0, last_gap = 0;
  int   sclk_edges = 0, done_cnt = 0, done_pos_bad = 0, period_bad = 0;
  int   lead_cyc = 0, exp_period = 2;
  logic prev_act = 1'b0, prev_sclk = 1'b0, first_lead = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (cs_act === 1'b1) begin
      if (!prev_act) begin
        last_gap   = high_run;
        first_lead = 1'b1;
      end
      low_run++;
      high_run = 0;
      if (sclk !== prev_sclk) begin
        sclk_edges++;
        if (sclk !== cur_cpol) begin
          if (!first_lead && (cyc - lead_cyc) != exp_period) period_bad++;
          first_lead = 1'b0;
          lead_cyc   = cyc;
        end
      end
    end else begin
      if (prev_act) last_low = low_run;
      low_run = 0;
      high_run++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (cs_act === 1'b1 || !prev_act) done_pos_bad++;
    end
    prev_act  = (cs_act === 1'b1);
    prev_sclk = sclk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input logic [63:0] tx, input int l, input int sel, input int div,
                       input logic pol, input logic pha, input logic [63:0] sw, input logic lp);
    tick();
    tx_data = tx; len = 3'(l); cs_sel = 2'(sel); clk_div = 8'(div);
    cpol = pol; cpha = pha;
    cur_cpol = pol; cur_cpha = pha; s_word = sw; loopback = lp;
    exp_period = 2 * (div + 1);
    tick(); tick();
    sclk_edges = 0; done_cnt = 0; period_bad = 0; done_pos_bad = 0;
  endtask

  task automatic launch(input logic [63:0] tx, input int l, input int sel, input int div,
                        input logic pol, input logic pha, input logic [63:0] sw, input logic lp);
    setup(tx, l, sel, div, pol, pha, sw, lp);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, " done_seen"}, 64'(done), 64'd1);
  endtask

  // checks made in the done cycle, from the transfer's own parameters
  task automatic check_result(input string tag, input logic [63:0] tx, input int l, input int div,
                              input logic [63:0] sw, input logic lp);
    int n = 8 * (l + 1);
    int d = div + 1;
    logic [63:0] mask = ~64'h0 << (64 - n);
    chk({tag, " rx_data"}, rx_data, (lp ? tx : sw) & mask);
    chk({tag, " slave_rx"}, s_rx, tx >> (64 - n));
    chk({tag, " cs_low_cycles"}, 64'(last_low), 64'(d * (2 * n + 2)));
    chk({tag, " sclk_edges"}, 64'(sclk_edges), 64'(2 * n));
    chk({tag, " sclk_period"}, 64'(period_bad), 64'd0);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_position"}, 64'(done_pos_bad), 64'd0);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_xfer(input string tag, input logic [63:0] tx, input int l, input int div,
                            input logic pol, input logic [63:0] sw, input logic lp);
    check_result(tag, tx, l, div, sw, lp);
    tick();
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " sclk_idle"}, 64'(sclk), 64'(pol));
    chk({tag, " rx_stable"}, rx_data, (lp ? tx : sw) & (~64'h0 << (64 - 8 * (l + 1))));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] t1, t2, w1, w2;
    int n;

    // reset state
    repeat (3) tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset cs_n", 64'(cs_n), 64'hF);
    chk("reset sclk", 64'(sclk), 64'd0);
    chk("reset mosi", 64'(mosi), 64'd0);
    chk("reset rx_data", rx_data, 64'd0);
    rst = 1'b0;

    // 1: mode 0, one byte, fastest clock, loopback
    t1 = {8'hA5, 56'($urandom) ^ {24'h0, 32'($urandom)}};
    launch(t1, 0, 0, 0, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("t1 cs_n_sel0", 64'(cs_n), 64'hE);
    wait_done("t1");
    check_xfer("t1", t1, 0, 0, 1'b0, 64'h0, 1'b1);

    // 2: mode 3, eight bytes, D=4
    t1 = {$urandom, $urandom};
    launch(t1, 7, 1, 3, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    wait_done("t2");
    check_xfer("t2", t1, 7, 3, 1'b1, 64'h0123456789ABCDEF, 1'b0);

    // 3: modes 1 and 2, two bytes
    w1 = {$urandom, $urandom};
    launch(64'hC33C_0000_0000_0000, 1, 0, 1, 1'b0, 1'b1, w1, 1'b0);
    wait_done("t3m1");
    check_xfer("t3m1", 64'hC33C_0000_0000_0000, 1, 1, 1'b0, w1, 1'b0);
    w1 = {$urandom, $urandom};
    launch(64'hC33C_0000_0000_0000, 1, 3, 2, 1'b1, 1'b0, w1, 1'b0);
    wait_done("t3m2");
    check_xfer("t3m2", 64'hC33C_0000_0000_0000, 1, 2, 1'b1, w1, 1'b0);

    // 4: second start while busy, with different inputs, is ignored
    t1 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    launch(t1, 3, 0, 1, 1'b0, 1'b0, w1, 1'b0);
    repeat (10) tick();
    tx_data = ~t1; len = 3'd7; cpha = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4");
    check_xfer("t4", t1, 3, 1, 1'b0, w1, 1'b0);
    repeat (40) tick();
    chk("t4 no_second_transfer", 64'(done_cnt), 64'd1);
    chk("t4 idle_busy", 64'(busy), 64'd0);

    // 5: start held through the done cycle -> back-to-back transfer
    t1 = {$urandom, $urandom};
    t2 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    setup(t1, 2, 1, 0, 1'b0, 1'b1, w1, 1'b0);
    start = 1'b1;
    tick();
    wait_done("t5a");
    check_result("t5a", t1, 2, 0, w1, 1'b0);
    tx_data = t2; s_word = w2;
    sclk_edges = 0; done_cnt = 0; period_bad = 0; done_pos_bad = 0;
    tick();
    start = 1'b0;
    chk("t5 second_accept_busy", 64'(busy), 64'd1);
    wait_done("t5b");
    chk("t5 cs_gap", 64'(last_gap), 64'd1);
    check_xfer("t5b", t2, 2, 0, 1'b0, w2, 1'b0);

    // 6: cs_sel=2 of 4, reset at bit 20, then a normal transfer
    t1 = {$urandom, $urandom};
    launch(t1, 7, 2, 0, 1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    chk("t6 cs_n_sel2", 64'(cs_n), 64'hB);
    n = 0;
    while (sclk_edges < 40 && n < 2000) begin
      tick();
      n++;
    end
    chk("t6 reached_bit20", 64'(sclk_edges >= 40), 64'd1);
    chk("t6 busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6 rst cs_n", 64'(cs_n), 64'hF);
    chk("t6 rst sclk", 64'(sclk), 64'd0);
    chk("t6 rst busy", 64'(busy), 64'd0);
    chk("t6 rst done", 64'(done), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6 no_done_after_rst", 64'(done_cnt), 64'd0);
    t1 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    launch(t1, 4, 2, 2, 1'b0, 1'b0, w1, 1'b0);
    chk("t6b cs_n_sel2", 64'(cs_n), 64'hB);
    wait_done("t6b");
    check_xfer("t6b", t1, 4, 2, 1'b0, w1, 1'b0);

    // random transfers
    for (int i = 0; i < 6; i++) begin
      logic [1:0] m;
      int l, d, s;
      m = 2'($urandom_range(0, 3));
      l = $urandom_range(0, 7);
      d = $urandom_range(0, 3);
      s = $urandom_range(0, 3);
      t1 = {$urandom, $urandom};
      w1 = {$urandom, $urandom};
      launch(t1, l, s, d, m[1], m[0], w1, 1'b0);
      wait_done($sformatf("rnd%0d", i));
      check_xfer($sformatf("rnd%0d", i), t1, l, d, m[1], w1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
